// File: rtl/vect_deser.sv
// vect_deser: serial-to-parallel deserializer.
// Collects qualified serial bits into WIDTH-bit words and offers each
// completed word on a registered output with a valid/ready handshake.
// i_sync restarts the frame, MSB_FIRST selects the bit order, and a
// word that completes while the output slot is still full is dropped
// and reported through a sticky overrun flag.
module vect_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit,
  input  logic             i_bit_en,
  input  logic             i_sync,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [CW-1:0]    o_fill
);

  // Fill count of the final bit of a frame.
  localparam logic [CW-1:0] LAST_FILL = CW'(WIDTH - 1);
  // Word position that bit 0 of a frame occupies.
  localparam int FIRST_POS = MSB_FIRST ? (WIDTH - 1) : 0;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [CW-1:0]    fill_q, fill_d;

  logic [CW-1:0]    posIdx;
  logic [WIDTH-1:0] bitMask;
  logic [WIDTH-1:0] firstMask;
  logic [WIDTH-1:0] merged;
  logic             slotFree;

  // Where the incoming bit lands and the partial word with it merged in.
  always_comb begin
    posIdx    = MSB_FIRST ? (LAST_FILL - fill_q) : fill_q;
    bitMask   = '0;
    bitMask[posIdx] = 1'b1;
    firstMask = '0;
    firstMask[FIRST_POS] = 1'b1;
    merged    = (shreg_q & ~bitMask) | ({WIDTH{i_bit}} & bitMask);
    slotFree  = !valid_q || i_ready;
  end

  // Next-state logic: frame assembly, output slot handshake, overrun.
  // The shift register is cleared whenever a frame ends so that no bit of
  // a previous frame can ever reach o_word.
  always_comb begin
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fill_d  = fill_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end

    if (i_sync) begin
      if (i_bit_en) begin
        shreg_d = {WIDTH{i_bit}} & firstMask;
        fill_d  = CW'(1);
      end else begin
        shreg_d = '0;
        fill_d  = '0;
      end
    end else if (i_bit_en) begin
      if (fill_q == LAST_FILL) begin
        shreg_d = '0;
        fill_d  = '0;
        if (slotFree) begin
          word_d  = merged;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        shreg_d = merged;
        fill_d  = fill_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fill_q  <= fill_d;
    end
  end

  assign o_word    = word_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
  assign o_fill    = fill_q;

endmodule

// File: tb/tb_vect_deser.sv
// Testbench for vect_deser: two instances (LSB-first and MSB-first) share
// one stimulus stream and are compared every cycle against a frame-queue
// model, with literal expectations from hand-worked frames.
module tb_vect_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk;
  logic          rst_n;
  logic          bitIn;
  logic          bitEn;
  logic          sync;
  logic          ready;
  logic          ovrClr;

  logic [W-1:0]  wordL, wordM;
  logic          validL, validM;
  logic          ovrL, ovrM;
  logic [CW-1:0] fillL, fillM;

  vect_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bitIn), .i_bit_en(bitEn),
    .i_sync(sync), .i_ready(ready), .i_ovr_clr(ovrClr),
    .o_word(wordL), .o_valid(validL), .o_overrun(ovrL), .o_fill(fillL)
  );

  vect_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bitIn), .i_bit_en(bitEn),
    .i_sync(sync), .i_ready(ready), .i_ovr_clr(ovrClr),
    .o_word(wordM), .o_valid(validM), .o_overrun(ovrM), .o_fill(fillM)
  );

  int nChecks = 0;
  int nPass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits of the current frame in arrival order, plus the
  // output slot contents for both bit orders.
  bit       frame[$];
  bit [W-1:0] mWordL, mWordM;
  bit       mValid, mOvr;

  always @(posedge clk or negedge rst_n) begin
    bit validPre;
    bit [W-1:0] wl, wm;
    if (!rst_n) begin
      frame.delete();
      mWordL = '0;
      mWordM = '0;
      mValid = 1'b0;
      mOvr   = 1'b0;
    end else begin
      validPre = mValid;
      if (ovrClr) mOvr = 1'b0;
      if (validPre && ready) mValid = 1'b0;
      if (sync) begin
        frame.delete();
        if (bitEn) frame.push_back(bitIn);
      end else if (bitEn) begin
        frame.push_back(bitIn);
        if (frame.size() == W) begin
          wl = '0;
          wm = '0;
          for (int k = 0; k < W; k++) begin
            wl[k]       = frame[k];
            wm[W-1-k]   = frame[k];
          end
          frame.delete();
          if (!validPre || ready) begin
            mWordL = wl;
            mWordM = wm;
            mValid = 1'b1;
          end else begin
            mOvr = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("wordL",  32'(wordL),  32'(mWordL));
      checkOutput("wordM",  32'(wordM),  32'(mWordM));
      checkOutput("validL", 32'(validL), 32'(mValid));
      checkOutput("validM", 32'(validM), 32'(mValid));
      checkOutput("ovrL",   32'(ovrL),   32'(mOvr));
      checkOutput("ovrM",   32'(ovrM),   32'(mOvr));
      checkOutput("fillL",  32'(fillL),  32'(frame.size()));
      checkOutput("fillM",  32'(fillM),  32'(frame.size()));
    end
  end

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic applyStimulus(input logic b, input logic en, input logic sy,
                               input logic rd, input logic clr);
    bitIn  = b;
    bitEn  = en;
    sync   = sy;
    ready  = rd;
    ovrClr = clr;
    @(negedge clk);
  endtask

  // Send a full frame, bit k of value first-to-last (LSB-first word value).
  task automatic sendWord(input logic [W-1:0] value, input logic rd,
                          input logic lastRd);
    for (int k = 0; k < W; k++)
      applyStimulus(value[k], 1'b1, 1'b0, (k == W-1) ? lastRd : rd, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pattern;
    pattern = 8'h83;
    rst_n = 1'b0;
    bitIn = 0; bitEn = 0; sync = 0; ready = 0; ovrClr = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_word",  32'(wordL),  32'h0);
    checkOutput("reset_valid", 32'(validL), 32'h0);
    checkOutput("reset_fill",  32'(fillL),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, ready high, both bit orders.
    for (int k = 0; k < W; k++) begin
      applyStimulus(pattern[k], 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("seq_fill", 32'(fillL), 32'((k + 1) % W));
    end
    checkOutput("lsb_word", 32'(wordL),  32'h83);
    checkOutput("msb_word", 32'(wordM),  32'hC1);
    checkOutput("lsb_valid", 32'(validL), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("valid_one_cycle", 32'(validL), 32'h0);

    // Same frame with 3-cycle gaps; fill must hold.
    for (int k = 0; k < W; k++) begin
      applyStimulus(pattern[k], 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("gap_fill", 32'(fillM), 32'((k + 1) % W));
    end
    checkOutput("gap_msb_word", 32'(wordM), 32'hC1);

    // Backpressure: second frame is dropped.
    sendWord(8'h83, 1'b0, 1'b0);
    sendWord(8'h55, 1'b0, 1'b0);
    checkOutput("bp_word",  32'(wordL),  32'h83);
    checkOutput("bp_valid", 32'(validL), 32'h1);
    checkOutput("bp_ovr",   32'(ovrL),   32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_ovr",   32'(ovrL),   32'h0);
    checkOutput("clr_valid", 32'(validL), 32'h0);

    // Drain and load in the same cycle.
    sendWord(8'h83, 1'b0, 1'b0);
    sendWord(8'h3C, 1'b0, 1'b1);
    checkOutput("dl_word",  32'(wordL),  32'h3C);
    checkOutput("dl_valid", 32'(validL), 32'h1);
    checkOutput("dl_ovr",   32'(ovrL),   32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resync mid-frame.
    for (int k = 0; k < 5; k++)
      applyStimulus(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("sync_fill",  32'(fillL),  32'h1);
    checkOutput("sync_valid", 32'(validL), 32'h0);
    for (int k = 0; k < 7; k++)
      applyStimulus((k == 6), 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("sync_word",  32'(wordL),  32'h81);
    checkOutput("sync_valid2", 32'(validL), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame with a pending word.
    sendWord(8'hA7, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_word",  32'(wordL),  32'h0);
    checkOutput("arst_valid", 32'(validL), 32'h0);
    checkOutput("arst_fill",  32'(fillL),  32'h0);
    checkOutput("arst_ovr",   32'(ovrL),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bitEn = 1'b0;
    @(negedge clk);
    sendWord(8'h6D, 1'b0, 1'b0);
    checkOutput("post_rst_word",  32'(wordL),  32'h6D);
    checkOutput("post_rst_valid", 32'(validL), 32'h1);

    // Randomised traffic checked by the per-cycle comparator.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'($urandom_range(1)),
                    ($urandom_range(3) != 0),
                    ($urandom_range(15) == 0),
                    ($urandom_range(1) == 1),
                    ($urandom_range(7) == 0));
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/vect_deser.md
# vect_deser

Parametrised serial-to-parallel deserializer. It assembles a qualified serial bit stream into WIDTH-bit words and presents each word on a registered output with a valid/ready handshake. It also provides frame resynchronisation, selectable bit order and sticky overrun detection. It sits between a bit-level receiver front end and word-level consumers, and supersedes the fixed 8-bit, free-running vector assembler.

## Interface
- WIDTH, 8, word width in bits; legal values ≥ 2.
- MSB_FIRST, 0, bit order. 0: first received bit lands in o_word[0]. 1: first received bit lands in o_word[WIDTH-1].
- CW, derived as $clog2(WIDTH), width of o_fill; not overridable.

Ports:
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low. Asserting it clears all state immediately. Deassertion is synchronous to i_clk at system level.
- i_bit  in  1  serial data bit; sampled only when i_bit_en=1.
- i_bit_en  in  1  sample strobe; one bit is accepted per cycle in which it is high.
- i_sync  in  1  frame restart; discards the partial word.
- i_ready  in  1  consumer accepts o_word when i_ready=1 and o_valid=1.
- i_ovr_clr  in  1  clears o_overrun.
- o_word  out  WIDTH  last completed word (registered).
- o_valid  out  1  o_word holds an unconsumed word.
- o_overrun  out  1  sticky: a completed word was dropped.
- o_fill  out  CW  number of bits held in the partial word (0..WIDTH-1).

## Operation
- Reset values: o_word=0, o_valid=0, o_overrun=0, o_fill=0, internal shift register=0.
- Accept (i_bit_en=1, i_sync=0, o_fill<WIDTH-1):
  - Bit k of the frame (k=o_fill) is written to position k (MSB_FIRST=0) or WIDTH-1-k (MSB_FIRST=1).
  - o_fill increments by 1.
- Complete (i_bit_en=1, i_sync=0, o_fill=WIDTH-1):
  - The final bit is merged and the full word is formed.
  - o_fill wraps to 0.
  - If the output slot is free (o_valid=0) or drains this cycle (o_valid=1 and i_ready=1): o_word ← word and o_valid=1 next cycle.
  - Otherwise the word is dropped, o_word and o_valid are unchanged, and o_overrun is set.
- Handshake: on o_valid=1 and i_ready=1 with no completion in the same cycle, o_valid=0 next cycle and o_word holds its value.
  - o_word changes only on a load.
  - o_valid never drops without a handshake.
- i_sync=1:
  - The partial word is discarded and no word is emitted, including on a cycle where completion would otherwise occur.
  - With i_bit_en=1, i_bit becomes bit 0 of the new frame and o_fill=1 next cycle.
  - With i_bit_en=0, o_fill=0 next cycle.
  - The output slot and handshake are unaffected.
- i_bit_en=0 and i_sync=0: partial state holds and o_fill is unchanged. Gaps of any length are legal.
- Overrun:
  - o_overrun stays 1 until i_ovr_clr=1.
  - If a set event and i_ovr_clr occur in the same cycle, set wins and o_overrun stays 1.
- Stale bit positions of the partial word are never visible on o_word. Every bit of a loaded word comes from the current frame.

## Timing
- Latency: when the last bit is sampled at edge N, o_valid=1 and o_word are valid after edge N. This is 1 cycle, with no combinational path from i_bit to outputs.
- Throughput: one word per WIDTH strobe cycles. With i_ready tied high, back-to-back frames with no gap never overrun.
- i_ready is sampled on the same edge as the completion check; a drain and a load in the same cycle is legal.
- o_fill and o_overrun are registered and update on the edge after the triggering event.
- Reset mid-frame clears the partial word and any pending o_valid word. The first strobe after reset is bit 0.

## Test plan
- WIDTH=8, MSB_FIRST=0, i_ready=1: strobe bits 1,1,0,0,0,0,0,1 on consecutive cycles → o_word=0x83 and o_valid high for 1 cycle, one cycle after the 8th strobe; o_fill sequence 1..7,0.
- WIDTH=8, MSB_FIRST=1: same bit sequence, with idle gaps of 3 cycles between strobes → o_word=0xC1; o_fill holds during the gaps.
- Backpressure: i_ready=0 and send two full frames 0x83 then 0x55 → o_word stays 0x83, o_valid=1, o_overrun=1 after the second frame completes. Then pulse i_ovr_clr and i_ready → o_overrun=0 and o_valid=0.
- Drain and load in the same cycle: hold 0x83 with o_valid=1, and assert i_ready on the cycle the next frame (0x3C) completes → o_word=0x3C, o_valid stays 1, o_overrun=0.
- Resync: send 5 bits, then i_sync=1 with i_bit_en=1 and i_bit=1, followed by 7 bits 0,0,0,0,0,0,1 → only the new word is emitted, o_word=0x81 (MSB_FIRST=0); o_fill=1 after the sync cycle.
- Reset mid-frame: after 4 bits with o_valid=1, pulse i_rst_n low asynchronously (between edges) → all outputs 0 immediately. The next 8 strobes form a complete word.
